// File: rtl/bf_uart_tx.sv
// Byte FIFO feeding an 8N1 UART transmitter for the BF core '.' output.
// tx is registered from the next-state decode so it stays glitch-free.
module bf_uart_tx #(
  parameter int CLKS_PER_BIT   = 16,
  parameter int FIFO_ADDR_SIZE = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [7:0]              i_out,
  input  logic                    i_out_enable,
  output logic                    o_out_ready,
  output logic                    o_tx,
  output logic                    o_busy,
  output logic                    o_overflow,
  input  logic                    i_overflow_clear,
  output logic [FIFO_ADDR_SIZE:0] o_fifo_count
);

  localparam int DEPTH = 2 ** FIFO_ADDR_SIZE;
  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0]           TMAX    = TW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_ADDR_SIZE:0] DEPTH_C = (FIFO_ADDR_SIZE + 1)'(DEPTH);
  localparam logic [FIFO_ADDR_SIZE:0] CNT_ONE = (FIFO_ADDR_SIZE + 1)'(1);
  localparam logic [FIFO_ADDR_SIZE-1:0] PTR_ONE = FIFO_ADDR_SIZE'(1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                    r_state, w_state_nxt;
  logic [TW-1:0]             r_timer, w_timer_nxt;
  logic [2:0]                r_idx, w_idx_nxt;
  logic [7:0]                r_shift, w_shift_nxt;
  logic                      r_tx, w_tx_nxt;
  logic [FIFO_ADDR_SIZE-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_ADDR_SIZE:0]   r_count;
  logic                      r_ovf;
  logic [7:0]                r_mem [DEPTH];
  logic                      w_push, w_drop, w_pop;

  // Readiness comes from the registered count only, so a pop in the same
  // cycle never lets a full FIFO take another byte.
  assign o_out_ready  = (r_count < DEPTH_C);
  assign w_push       = i_out_enable & o_out_ready;
  assign w_drop       = i_out_enable & ~o_out_ready;
  assign o_tx         = r_tx;
  assign o_overflow   = r_ovf;
  assign o_fifo_count = r_count;
  assign o_busy       = (r_state != S_IDLE) | (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_out;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (w_pop && !w_push) r_count <= r_count - CNT_ONE;
      if (w_drop)                r_ovf <= 1'b1;
      else if (i_overflow_clear) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_shift_nxt = r_mem[r_rd_ptr];
          w_timer_nxt = '0;
          w_idx_nxt   = '0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_timer == TMAX) begin
          w_timer_nxt = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_DATA: begin
        if (r_timer == TMAX) begin
          w_timer_nxt = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_idx == 3'd7) w_state_nxt = S_STOP;
          else               w_idx_nxt   = r_idx + 3'd1;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      S_STOP: begin
        if (r_timer == TMAX) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line level for the cycle that follows this edge.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_bf_uart_tx.sv
// Directed bench for bf_uart_tx at CLKS_PER_BIT=4, depth 8, with a
// negedge-sampling UART receiver decoding the serial line.
module tb_bf_uart_tx;

  logic       clk, rst_n;
  logic [7:0] din;
  logic       en, ovf_clr;
  logic       ready, tx, busy, ovf;
  logic [3:0] cnt;

  int n_chk = 0, n_pass = 0;
  int frame_err = 0;
  int cyc_n = 0;
  logic [7:0] rxq[$];
  int         starts[$];

  bf_uart_tx #(.CLKS_PER_BIT(4), .FIFO_ADDR_SIZE(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_out(din), .i_out_enable(en),
    .o_out_ready(ready), .o_tx(tx), .o_busy(busy), .o_overflow(ovf),
    .i_overflow_clear(ovf_clr), .o_fifo_count(cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected done");
    $fatal(1);
  end

  // Receiver: start bit at first low sample, data mid-bit at 4k+2, stop at 38.
  int         rx_cnt = 0;
  bit         rx_act = 0;
  logic [7:0] rx_sh;
  always @(negedge clk) begin
    cyc_n++;
    if (!rst_n) begin
      rx_act = 0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1; rx_cnt = 0; rx_sh = '0;
        starts.push_back(cyc_n);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt == 2 && tx !== 1'b0) frame_err++;
      if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) rx_sh[(rx_cnt - 6) / 4] = tx;
      if (rx_cnt == 38) begin
        if (tx !== 1'b1) frame_err++;
        rxq.push_back(rx_sh);
        rx_act = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rx(input int n, input string tag);
    int b = 0;
    while (rxq.size() < n && b < 3000) begin tick(); b++; end
    chk({tag, "_timeout"}, 64'(rxq.size() >= n), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int b = 0;
    while ((busy !== 1'b0 || rx_act) && b < 3000) begin tick(); b++; end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  logic [41:0] wv, exp_wv;
  int fb[10];
  int sizes[5];
  int k;

  initial begin
    rst_n = 1'b1; en = 1'b0; ovf_clr = 1'b0; din = 8'h00;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tx", 64'(tx), 64'd1);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_count", 64'(cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    en = 1'b1; din = 8'h77;
    tick(); tick();
    chk("rst_ignores_en", 64'(cnt), 64'd0);
    en = 1'b0;
    rst_n = 1'b1;

    // Single byte 0x48: exact waveform over 42 negedge samples.
    fb = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 1};
    exp_wv = '0;
    exp_wv[0] = 1'b1;
    for (int i = 1; i <= 40; i++) exp_wv[i] = fb[(i - 1) / 4][0];
    exp_wv[41] = 1'b1;
    en = 1'b1; din = 8'h48;
    tick();
    en = 1'b0;
    chk("first_push_count", 64'(cnt), 64'd1);
    for (int i = 0; i < 42; i++) begin
      @(negedge clk);
      wv[i] = tx;
      if (i == 1)  chk("single_popped", 64'(cnt), 64'd0);
      if (i == 40) chk("single_busy_stop", 64'(busy), 64'd1);
      if (i == 41) chk("single_busy_end", 64'(busy), 64'd0);
    end
    chk("single_wave", 64'(wv), 64'(exp_wv));
    #1;
    wait_rx(1, "single");
    chk("single_rx", 64'(rxq[0]), 64'h48);

    // Burst of 10 into an idle block, then overflow clear and full-FIFO pop race.
    tick();
    rxq.delete(); starts.delete();
    for (int i = 0; i < 10; i++) begin
      en = 1'b1; din = 8'(8'h10 + i);
      if (i == 9) chk("burst_ready10", 64'(ready), 64'd0);
      tick();
    end
    en = 1'b0;
    chk("burst_ovf", 64'(ovf), 64'd1);
    chk("burst_count", 64'(cnt), 64'd8);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_alone", 64'(ovf), 64'd0);
    ovf_clr = 1'b1; en = 1'b1; din = 8'hEE;
    tick();
    en = 1'b0;
    chk("clr_vs_drop", 64'(ovf), 64'd1);
    chk("drop_count", 64'(cnt), 64'd8);
    tick();
    ovf_clr = 1'b0;
    chk("clr_again", 64'(ovf), 64'd0);
    repeat (29) tick();
    chk("full_before_pop", 64'(cnt), 64'd8);
    en = 1'b1; din = 8'hDD;
    chk("full_not_ready", 64'(ready), 64'd0);
    tick();
    en = 1'b0;
    chk("full_pop_drop_count", 64'(cnt), 64'd7);
    chk("full_pop_drop_ovf", 64'(ovf), 64'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    wait_rx(9, "burst");
    for (int i = 0; i < 9; i++) chk($sformatf("burst_rx%0d", i), 64'(rxq[i]), 64'(8'h10 + i));
    for (int i = 0; i < 8; i++) chk($sformatf("burst_gap%0d", i), 64'(starts[i + 1] - starts[i]), 64'd41);
    wait_idle("burst");

    // Reset in DATA bit 3 of 0xA5 (bit value 0) with a second byte buffered.
    tick();
    rxq.delete();
    en = 1'b1; din = 8'hA5; tick();
    din = 8'h3C; tick();
    en = 1'b0;
    repeat (17) tick();
    chk("pre_rst_tx", 64'(tx), 64'd0);
    chk("pre_rst_count", 64'(cnt), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 64'(tx), 64'd1);
    chk("mid_rst_count", 64'(cnt), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd1);
    tick(); tick();
    rst_n = 1'b1;
    en = 1'b1; din = 8'h5A; tick();
    en = 1'b0;
    chk("post_rst_push", 64'(cnt), 64'd1);
    wait_rx(1, "post_rst");
    chk("post_rst_rx", 64'(rxq[0]), 64'h5A);
    chk("post_rst_nframes", 64'(rxq.size()), 64'd1);
    wait_idle("post_rst");

    // 20 distinct bytes in mixed bursts with pointer wrap.
    rxq.delete();
    sizes = '{3, 5, 1, 8, 3};
    k = 0;
    for (int s = 0; s < 5; s++) begin
      int b = 0;
      while (int'(cnt) > 8 - sizes[s] && b < 3000) begin tick(); b++; end
      for (int j = 0; j < sizes[s]; j++) begin
        en = 1'b1; din = 8'(8'h30 + k * 7); k++;
        tick();
      end
      en = 1'b0;
      repeat ($urandom_range(0, 30)) tick();
    end
    wait_rx(20, "wrap");
    for (int i = 0; i < 20; i++) chk($sformatf("wrap_rx%0d", i), 64'(rxq[i]), 64'(8'(8'h30 + i * 7)));
    chk("wrap_ovf", 64'(ovf), 64'd0);
    wait_idle("wrap");
    chk("frame_errors", 64'(frame_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bf_uart_tx.md
BF_UART_TX -- requirements
Module: bf_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clock cycles per UART bit period (legal >= 2).
REQ-002 Parameter FIFO_ADDR_SIZE, default 3; FIFO depth = 2**FIFO_ADDR_SIZE bytes.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 out  input  8  byte emitted by the BF core ('.' instruction).
REQ-006 out_enable  input  1  one-cycle strobe; out valid this cycle.
REQ-007 out_ready  output  1  high when the FIFO can accept a byte this cycle.
REQ-008 tx  output  1  serial line, idle high, 8N1, LSB first.
REQ-009 busy  output  1  high when the FIFO is non-empty or a frame is in progress.
REQ-010 overflow  output  1  sticky flag: a byte was dropped.
REQ-011 overflow_clear  input  1  synchronous clear of overflow.
REQ-012 fifo_count  output  FIFO_ADDR_SIZE+1  bytes currently buffered.

Function
REQ-013 FIFO push: on posedge with out_enable=1 and out_ready=1, write out at the tail; fifo_count +1.
REQ-014 out_ready = (fifo_count < depth), from registered count only; a same-cycle pop does not make a full FIFO accept.
REQ-015 out_enable=1 while out_ready=0: byte dropped, FIFO unchanged, overflow set at that edge.
REQ-016 overflow_clear=1 clears overflow at the edge; a simultaneous drop wins (overflow stays 1).
REQ-017 Simultaneous push and pop: both occur, fifo_count unchanged, FIFO order preserved.
REQ-018 Pointers wrap modulo depth; FIFO is strictly first-in first-out.
REQ-019 FSM states: IDLE, START, DATA, STOP.
REQ-020 IDLE: tx=1; if fifo_count != 0, pop head into shift register, clear bit-timer and bit index, next state START.
REQ-021 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-022 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit 7, go to STOP.
REQ-023 STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-024 Frame length: 10*CLKS_PER_BIT cycles of START..STOP; back-to-back frames are separated by exactly one IDLE cycle.
REQ-025 Latency: out_enable sampled at edge N with IDLE and FIFO empty -> pop at edge N+1 -> tx low from edge N+1 onward.
REQ-026 tx is driven from a register (glitch-free).
REQ-027 busy = (state != IDLE) | (fifo_count != 0), combinational from registers.
REQ-028 out_enable is ignored while reset is asserted.

Reset
REQ-029 While reset=0, immediately and asynchronously: state=IDLE, tx=1, fifo_count=0, pointers=0, overflow=0, busy=0, out_ready=1.
REQ-030 Reset asserted mid-frame aborts the frame; tx returns to 1 without completing the stop bit; buffered bytes are lost.
REQ-031 FIFO storage contents need no reset; only pointers and count are reset.
REQ-032 First push is accepted on the first posedge after reset deasserts.

Verification (CLKS_PER_BIT=4, FIFO_ADDR_SIZE=3)
REQ-033 Single byte: push 0x48 -> tx for 40 cycles from edge N+1 is 0 | 0,0,0,1,0,0,1,0 | 1 (4 cycles each), then idle 1; busy falls once the frame ends.
REQ-034 Burst: 10 pushes on consecutive cycles into an idle block -> 9 bytes accepted, 10th dropped, overflow=1, out_ready=0 on the 10th cycle; tx sends the 9 bytes in order with 1 idle cycle between frames.
REQ-035 Overflow clear: assert overflow_clear alone -> overflow=0 next cycle; with clear and a drop in the same cycle -> overflow stays 1.
REQ-036 Full FIFO with simultaneous pop: fifo_count=8 and a pop occur in the cycle of an out_enable -> byte dropped, fifo_count=7 afterwards.
REQ-037 Reset mid-frame: assert reset during DATA bit 3 -> tx=1 in the same cycle, fifo_count=0, busy=0; a new push after release sends a clean frame.
REQ-038 Wrap-around: push/pop 20 distinct bytes in mixed bursts -> serialized output equals input order exactly.
